// File: rtl/alu_pkg.sv
// Shared ALU opcodes, FSM encoding and single-cycle result function.
// Imported by alu_exec and the ALU control stage.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_XOR  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_ADD  = 4'b0011,
        ALU_SUB  = 4'b0100,
        ALU_MUL  = 4'b0101,
        ALU_ADDI = 4'b0110,
        ALU_SRAI = 4'b0111,
        ALU_OR   = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MUL_RUN = 2'b01,
        ST_DONE    = 2'b10
    } alu_state_e;

    // Every opcode except MUL; unknown codes yield zero.
    function automatic logic [XLEN-1:0] alu_compute(
        input logic [3:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0]        r;
        logic signed [XLEN-1:0] sa;
        r  = '0;
        sa = $signed(a);
        case (op)
            ALU_AND:           r = a & b;
            ALU_XOR:           r = a ^ b;
            ALU_OR:            r = a | b;
            ALU_SLL:           r = a << b[4:0];
            ALU_SRAI:          r = sa >>> b[4:0];
            ALU_ADD, ALU_ADDI: r = a + b;
            ALU_SUB:           r = a - b;
            default:           r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier iterator: one partial product per step.
// product is the accumulator value after the current step.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] product,
    output logic             last
);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [4:0]       cnt_q;

    assign product = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign last    = (cnt_q == 5'd31);

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            mcand_q  <= mcand;
            mplier_q <= mplier;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step) begin
            acc_q    <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 5'd1;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arith ops plus a 32-step
// iterative MUL; registered result with done/busy handshake.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             done_o,
    output logic             busy_o
);

    alu_state_e       state_q;
    alu_state_e       state_d;
    logic             mul_load;
    logic             mul_step;
    logic             mul_last;
    logic [WIDTH-1:0] mul_product;
    logic             res_load;
    logic [WIDTH-1:0] res_val;

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (mul_load),
        .step   (mul_step),
        .mcand  (data1_i),
        .mplier (data2_i),
        .product(mul_product),
        .last   (mul_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
        res_load = 1'b0;
        res_val  = '0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_i) begin
                    if (ctrl_i == ALU_MUL) begin
                        mul_load = 1'b1;
                        state_d  = ST_MUL_RUN;
                    end else begin
                        res_load = 1'b1;
                        res_val  = alu_compute(ctrl_i, data1_i, data2_i);
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_MUL_RUN: begin
                // start_i is deliberately ignored while iterating
                mul_step = 1'b1;
                if (mul_last) begin
                    res_load = 1'b1;
                    res_val  = mul_product;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o <= '0;
            zero_o <= 1'b1;
        end else if (res_load) begin
            data_o <= res_val;
            zero_o <= (res_val == '0);
        end
    end

    assign done_o = (state_q == ST_DONE);
    assign busy_o = (state_q == ST_MUL_RUN);

endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector self-checking bench for alu_exec.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_alu_exec;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic [3:0]  ctrl_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [31:0] data_o;
    logic        zero_o;
    logic        done_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec #(
        .WIDTH(32)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .start_i(start_i),
        .ctrl_i (ctrl_i),
        .data1_i(data1_i),
        .data2_i(data2_i),
        .data_o (data_o),
        .zero_o (zero_o),
        .done_o (done_o),
        .busy_o (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One single-cycle op from IDLE: start, then check the DONE cycle.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        start_i = 1'b1;
        ctrl_i  = op;
        data1_i = a;
        data2_i = b;
        tick();
        start_i = 1'b0;
        check({tag, "_done"}, {31'b0, done_o}, 32'd1);
        check({tag, "_data"}, data_o, exp);
        check({tag, "_zero"}, {31'b0, zero_o}, {31'b0, exp == 32'd0});
        tick();
        check({tag, "_idle"}, {31'b0, done_o}, 32'd0);
    endtask

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        ctrl_i  = 4'd0;
        data1_i = '0;
        data2_i = '0;
        tick();
        start_i = 1'b1;
        ctrl_i  = 4'b0011;
        data1_i = 32'd9;
        tick();
        rst_i   = 1'b0;
        start_i = 1'b0;
        check("rst_data", data_o, 32'd0);
        check("rst_zero", {31'b0, zero_o}, 32'd1);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);

        run_op("add_ovf", 4'b0011, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
        run_op("sub_eq", 4'b0100, 32'd5, 32'd5, 32'd0);
        run_op("srai", 4'b0111, 32'h8000_0000, 32'd4, 32'hF800_0000);
        run_op("or", 4'b1111, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0);
        run_op("and", 4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
        run_op("addi", 4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
               32'hFFFF_FFFD);
        run_op("sll_big", 4'b0010, 32'h0000_0003, 32'h0000_0021,
               32'h0000_0006);

        // MUL: busy for cycles 1..32, done in cycle 33
        start_i = 1'b1;
        ctrl_i  = 4'b0101;
        data1_i = 32'hFFFF_FFFF;
        data2_i = 32'd3;
        tick();
        start_i = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            check("mul_busy", {31'b0, busy_o}, 32'd1);
            check("mul_nodone", {31'b0, done_o}, 32'd0);
            data1_i = 32'h1234_5678 + i;
            data2_i = 32'hDEAD_0000 + i;
            start_i = (i == 5);
            ctrl_i  = (i == 5) ? 4'b0011 : 4'b0101;
            tick();
        end
        start_i = 1'b0;
        check("mul_done", {31'b0, done_o}, 32'd1);
        check("mul_busy_end", {31'b0, busy_o}, 32'd0);
        check("mul_data", data_o, 32'hFFFF_FFFD);
        check("mul_zero", {31'b0, zero_o}, 32'd0);
        tick();
        check("mul_idle", {31'b0, done_o}, 32'd0);

        // Back-to-back XOR then SLL
        start_i = 1'b1;
        ctrl_i  = 4'b0001;
        data1_i = 32'hA5A5_A5A5;
        data2_i = 32'hFFFF_0000;
        tick();
        check("b2b_done1", {31'b0, done_o}, 32'd1);
        check("b2b_xor", data_o, 32'h5A5A_A5A5);
        ctrl_i  = 4'b0010;
        data1_i = 32'd1;
        data2_i = 32'd31;
        tick();
        start_i = 1'b0;
        check("b2b_done2", {31'b0, done_o}, 32'd1);
        check("b2b_sll", data_o, 32'h8000_0000);
        tick();
        check("b2b_idle", {31'b0, done_o}, 32'd0);

        // Reset at MUL iteration 10
        start_i = 1'b1;
        ctrl_i  = 4'b0101;
        data1_i = 32'd7;
        data2_i = 32'd9;
        tick();
        start_i = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        check("abort_busy", {31'b0, busy_o}, 32'd1);
        check("abort_hold", data_o, 32'h8000_0000);
        rst_i   = 1'b1;
        start_i = 1'b1;
        ctrl_i  = 4'b0011;
        tick();
        rst_i   = 1'b0;
        start_i = 1'b0;
        check("abort_data", data_o, 32'd0);
        check("abort_zero", {31'b0, zero_o}, 32'd1);
        check("abort_done", {31'b0, done_o}, 32'd0);
        check("abort_busy0", {31'b0, busy_o}, 32'd0);
        for (int i = 0; i < 30; i++) begin
            tick();
            check("abort_nodone", {31'b0, done_o | busy_o}, 32'd0);
        end
        run_op("post_add", 4'b0011, 32'd2, 32'd3, 32'd5);

        run_op("undef", 4'b1000, 32'd123, 32'd456, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; only 32 is supported.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 start_i  input  1  request strobe; operands and ctrl_i sampled on an accepting edge.
REQ-005 ctrl_i  input  4  ALU control code from the ALU control stage.
REQ-006 data1_i  input  WIDTH  operand rs1.
REQ-007 data2_i  input  WIDTH  operand rs2 or sign-extended immediate.
REQ-008 data_o  output  WIDTH  registered result; holds until the next done_o.
REQ-009 zero_o  output  1  registered, high when data_o == 0.
REQ-010 done_o  output  1  one-cycle pulse marking data_o valid.
REQ-011 busy_o  output  1  high while a MUL iterates; the pipeline stalls on it.

Function
REQ-012 Codes: AND 0000, XOR 0001, SLL 0010, ADD 0011, SUB 0100, MUL 0101, ADDI 0110, SRAI 0111, OR 1111.
REQ-013 AND/XOR/OR bitwise; ADD and ADDI data1+data2 mod 2^32; SUB data1-data2 mod 2^32.
REQ-014 SLL shifts data1 left by data2[4:0]; SRAI shifts data1 arithmetic right by data2[4:0].
REQ-015 MUL yields the low 32 bits of data1*data2; signed and unsigned results are identical.
REQ-016 Any other code yields data_o = 0 with normal single-cycle timing.
REQ-017 FSM states are IDLE, MUL_RUN and DONE.
REQ-018 start_i is accepted in IDLE and DONE and ignored in MUL_RUN.
REQ-019 Accepted non-MUL op: result registered on the same edge; next state DONE; done_o high the following cycle (latency 1).
REQ-020 Accepted MUL: multiplicand, multiplier and a zeroed accumulator are loaded; 5-bit counter cleared; next state MUL_RUN.
REQ-021 MUL_RUN, each cycle: accumulator += multiplicand if multiplier[0]; multiplicand <<= 1; multiplier >>= 1; counter increments.
REQ-022 After the 32nd iteration (counter == 31) the accumulator goes to data_o and the next state is DONE; start-to-done_o latency is 33 cycles.
REQ-023 DONE holds done_o = 1 for exactly one cycle, then goes to IDLE unless a new start_i is accepted.
REQ-024 busy_o == (state == MUL_RUN), decoded from state with no extra register.
REQ-025 Back-to-back starts in consecutive DONE cycles give one done_o per operation with no bubble.
REQ-026 Operand inputs may change freely during MUL_RUN without affecting the result.
REQ-027 zero_o updates on the same edge as data_o.

Reset
REQ-028 When rst_i is high at an edge: state = IDLE; data_o = 0; zero_o = 1; done_o = 0; busy_o = 0; counter and MUL registers = 0.
REQ-029 Reset during MUL_RUN aborts the operation with no done_o; start_i is ignored while rst_i is high.

Structure
REQ-030 Opcodes and the state encoding are defined in shared package alu_pkg, also used by the ALU control stage.
REQ-031 The shift-add iterator is a single sub-module, alu_mul_iter (load, step, counter, product out); alu_exec owns the FSM and result mux.

Verification
REQ-032 Reset, then ADD 0x7FFFFFFF + 1: done_o one cycle later, data_o = 0x80000000, zero_o = 0.
REQ-033 SUB 5 - 5: data_o = 0, zero_o = 1; SRAI 0x80000000 by 4: data_o = 0xF8000000.
REQ-034 MUL 0xFFFFFFFF * 3: busy_o high for 32 cycles, done_o at cycle 33, data_o = 0xFFFFFFFD; a start_i pulse during busy_o is ignored.
REQ-035 Back-to-back XOR then SLL (1 << 31) in consecutive cycles: two done_o pulses, data_o = XOR result, then 0x80000000.
REQ-036 rst_i asserted at MUL iteration 10: no done_o; next cycle all outputs at their reset values; a subsequent ADD 2+3 gives 5.
REQ-037 ctrl_i = 1000 (undefined): data_o = 0, zero_o = 1, done_o after 1 cycle.
